// File: rtl/display_scheduler_if.sv
// Display path bundle: requester loads, scroll pulses, BCD converter loop and scan outputs.
interface display_scheduler_if;
    logic        clr;
    logic        l;
    logic        r;
    logic        req_a;
    logic [15:0] data_a;
    logic        req_b;
    logic [15:0] data_b;
    logic [19:0] bcd;
    logic        sign;
    logic [15:0] bin_out;
    logic        src_sel;
    logic [1:0]  offset;
    logic        tick;
    logic [1:0]  count;
    logic [3:0]  num;

    modport master (
        output clr, l, r, req_a, data_a, req_b, data_b, bcd, sign,
        input  bin_out, src_sel, offset, tick, count, num
    );

    modport slave (
        input  clr, l, r, req_a, data_a, req_b, data_b, bcd, sign,
        output bin_out, src_sel, offset, tick, count, num
    );
endinterface

// File: rtl/display_scheduler.sv
// Display scheduler: A/B ownership of the BCD converter, scroll offset, scan tick and digit codes.
// Latency: loads and scroll pulses land in 1 cycle; num refreshes on the next scan tick.
// Backpressure: none; loads are always taken, B beats A and A is dropped when both request.
module display_scheduler #(
    parameter int CLK_DIV = 250000,
    parameter int MAX_OFF = 2
) (
    input logic                clk,
    input logic                rst,
    display_scheduler_if.slave bus
);
    localparam int            DW         = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [1:0]    OFF_MAX    = 2'(MAX_OFF);
    localparam logic [3:0]    CODE_BLANK = 4'd14;
    localparam logic [3:0]    CODE_MINUS = 4'd15;

    logic [DW-1:0] div;
    logic [DW-1:0] div_nxt;
    logic [1:0]    cnt_nxt;
    logic [1:0]    k;
    logic [2:0]    pos;
    logic [4:0]    upper_zero;
    logic [3:0]    digit;
    logic [3:0]    code_nxt;

    assign div_nxt = (div == DIV_LAST) ? '0 : div + DW'(1);
    assign cnt_nxt = bus.count + 2'd1;
    assign k       = (cnt_nxt == 2'd3) ? 2'd0 : cnt_nxt;
    assign pos     = {1'b0, bus.offset} + {1'b0, k};

    // upper_zero[p]: every BCD digit from p up to the top digit is zero
    always_comb begin
        for (int p = 0; p < 5; p++) begin
            upper_zero[p] = ((bus.bcd >> (4 * p)) == 20'd0);
        end
    end

    always_comb begin
        case (pos)
            3'd0:    digit = bus.bcd[3:0];
            3'd1:    digit = bus.bcd[7:4];
            3'd2:    digit = bus.bcd[11:8];
            3'd3:    digit = bus.bcd[15:12];
            default: digit = bus.bcd[19:16];
        endcase
        if (cnt_nxt == 2'd3) begin
            code_nxt = bus.sign ? CODE_MINUS : CODE_BLANK;
        end else if ((pos != 3'd0) && upper_zero[pos]) begin
            code_nxt = CODE_BLANK;
        end else begin
            code_nxt = digit;
        end
    end

    // Scan divider free-runs through clr so the refresh rate never stutters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div      <= '0;
            bus.tick <= 1'b0;
        end else begin
            div      <= div_nxt;
            bus.tick <= (div_nxt == DIV_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.bin_out <= '0;
            bus.src_sel <= 1'b0;
            bus.offset  <= '0;
            bus.count   <= '0;
            bus.num     <= CODE_BLANK;
        end else if (bus.clr) begin
            bus.bin_out <= '0;
            bus.src_sel <= 1'b0;
            bus.offset  <= '0;
            bus.count   <= '0;
            bus.num     <= CODE_BLANK;
        end else begin
            if (bus.tick) begin
                bus.count <= cnt_nxt;
                bus.num   <= code_nxt;
            end
            if (bus.req_b) begin
                bus.bin_out <= bus.data_b;
                bus.src_sel <= 1'b1;
                bus.offset  <= '0;
            end else if (bus.req_a) begin
                bus.bin_out <= bus.data_a;
                bus.src_sel <= 1'b0;
                bus.offset  <= '0;
            end else if (bus.l && !bus.r) begin
                if (bus.offset < OFF_MAX) bus.offset <= bus.offset + 2'd1;
            end else if (bus.r && !bus.l) begin
                if (bus.offset != 2'd0) bus.offset <= bus.offset - 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_display_scheduler.sv
// Randomized bench for display_scheduler against a decimal-arithmetic reference model.
module tb_display_scheduler;
    localparam int CLK_DIV = 4;
    localparam int MAX_OFF = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    int m_bin, m_src, m_off, m_count, m_num, m_phase;

    display_scheduler_if bus ();

    display_scheduler #(.CLK_DIV(CLK_DIV), .MAX_OFF(MAX_OFF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic int mag_of(logic [15:0] b);
        int v;
        v = int'($signed(b));
        return (v < 0) ? -v : v;
    endfunction

    function automatic logic [19:0] to_bcd(int m);
        logic [19:0] res;
        res = '0;
        for (int i = 0; i < 5; i++) begin
            res[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return res;
    endfunction

    function automatic int pw10(int p);
        int res;
        res = 1;
        for (int i = 0; i < p; i++) res = res * 10;
        return res;
    endfunction

    // Behavioural converter closing the bin_out -> bcd/sign loop
    always_comb begin
        bus.bcd  = to_bcd(mag_of(bus.bin_out));
        bus.sign = bus.bin_out[15];
    end

    // Expected digit code from the decimal value itself
    function automatic int code_for(int k, int off, int bin);
        int p, m;
        if (k == 3) return (bin >= 32768) ? 15 : 14;
        p = off + k;
        m = mag_of(16'(bin));
        if (p > 0 && m < pw10(p)) return 14;
        return (m / pw10(p)) % 10;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("bin_out", int'(bus.bin_out), m_bin);
        chk("src_sel", int'(bus.src_sel), m_src);
        chk("offset",  int'(bus.offset),  m_off);
        chk("tick",    int'(bus.tick),    ((m_phase % CLK_DIV) == CLK_DIV - 1) ? 1 : 0);
        chk("count",   int'(bus.count),   m_count);
        chk("num",     int'(bus.num),     m_num);
    endtask

    task automatic model_reset();
        m_bin = 0; m_src = 0; m_off = 0; m_count = 0; m_num = 14; m_phase = 0;
    endtask

    task automatic cyc();
        bit pre_tick, c, l, r, ra, rb;
        int da, db;
        pre_tick = ((m_phase % CLK_DIV) == CLK_DIV - 1);
        c = bus.clr; l = bus.l; r = bus.r; ra = bus.req_a; rb = bus.req_b;
        da = int'(bus.data_a); db = int'(bus.data_b);
        @(posedge clk);
        #1;
        m_phase++;
        if (c) begin
            m_bin = 0; m_src = 0; m_off = 0; m_count = 0; m_num = 14;
        end else begin
            if (pre_tick) begin
                m_count = (m_count + 1) % 4;
                m_num   = code_for(m_count, m_off, m_bin);
            end
            if (rb) begin
                m_bin = db; m_src = 1; m_off = 0;
            end else if (ra) begin
                m_bin = da; m_src = 0; m_off = 0;
            end else if (l && !r) begin
                if (m_off < MAX_OFF) m_off++;
            end else if (r && !l) begin
                if (m_off > 0) m_off--;
            end
        end
        check_all();
    endtask

    task automatic drive(input bit c, input bit l, input bit r,
                         input bit ra, input int da, input bit rb, input int db);
        bus.clr = c; bus.l = l; bus.r = r;
        bus.req_a = ra; bus.data_a = 16'(da);
        bus.req_b = rb; bus.data_b = 16'(db);
    endtask

    task automatic pulse(input bit c, input bit l, input bit r,
                         input bit ra, input int da, input bit rb, input int db);
        drive(c, l, r, ra, da, rb, db);
        cyc();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    // Asynchronous reset mid-cycle: outputs must drop before any edge
    task automatic do_reset();
        #2 rst = 1'b0;
        model_reset();
        #1 check_all();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        do_reset();
        idle(13);

        pulse(0, 0, 0, 1, 7, 0, 0);
        idle(17);

        pulse(0, 0, 0, 1, 123, 1, 4567);
        chk("both_bin", int'(bus.bin_out), 4567);
        chk("both_src", int'(bus.src_sel), 1);
        chk("both_off", int'(bus.offset), 0);
        idle(16);

        pulse(0, 0, 0, 1, 12345, 0, 0);
        repeat (3) pulse(0, 1, 0, 0, 0, 0, 0);
        chk("sat_hi", int'(bus.offset), 2);
        idle(16);
        repeat (3) pulse(0, 0, 1, 0, 0, 0, 0);
        chk("sat_lo", int'(bus.offset), 0);
        idle(16);
        pulse(0, 1, 1, 0, 0, 0, 0);
        idle(4);

        pulse(0, 0, 0, 1, -42, 0, 0);
        idle(16);
        pulse(0, 0, 0, 1, 42, 0, 0);
        idle(16);

        pulse(0, 1, 0, 0, 0, 0, 0);
        pulse(0, 1, 0, 0, 0, 1, 99);
        chk("load_beats_l", int'(bus.offset), 0);
        idle(5);
        pulse(1, 0, 0, 0, 0, 1, 555);
        chk("clr_bin", int'(bus.bin_out), 0);
        chk("clr_src", int'(bus.src_sel), 0);
        chk("clr_num", int'(bus.num), 14);
        idle(9);

        for (int i = 0; i < 600; i++) begin
            int da, db;
            da = ($urandom_range(0, 1) == 1) ? int'(16'($urandom)) : int'($urandom_range(0, 999));
            db = ($urandom_range(0, 1) == 1) ? int'(16'($urandom)) : int'($urandom_range(0, 99));
            drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 15,
                  $urandom_range(0, 99) < 6, da, $urandom_range(0, 99) < 6, db);
            cyc();
            if (i == 300) begin
                drive(0, 0, 0, 0, 0, 0, 0);
                do_reset();
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/display_scheduler.md
# display_scheduler

Controller for the 7-segment display path: it chooses which of two 16-bit requesters (operand entry A, calculator result B) owns the display. It drives the binary value into the BCD converter, keeps the scroll-window offset from left/right pulses, and generates the scan tick and digit index. On each tick it produces the registered 4-bit digit code for the seven_seg driver, with leading-zero blanking and a sign digit.

## Interface
- CLK_DIV, 250000: clk cycles per scan tick (≥2); 100 MHz gives 400 Hz tick, 100 Hz per-digit refresh
- MAX_OFF, 2: maximum scroll offset (window of 3 digits over 5 BCD digits)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- clr  in  1  synchronous clear (active-high)
- l  in  1  scroll-left pulse, one clk cycle wide
- r  in  1  scroll-right pulse, one clk cycle wide
- req_a  in  1  load request from operand entry, one cycle
- data_a  in  16  value for req_a, sampled when req_a=1
- req_b  in  1  load request from result path, one cycle
- data_b  in  16  value for req_b, sampled when req_b=1
- bcd  in  20  converter output {tenth-thousands, thous, hunds, tens, ones}, combinational from bin_out
- sign  in  1  converter sign, 1 = negative
- bin_out  out  16  latched value to converter
- src_sel  out  1  owner of bin_out: 0 = A, 1 = B
- offset  out  2  current scroll offset, 0..MAX_OFF
- tick  out  1  one-cycle scan pulse
- count  out  2  digit index for anode select: 0,1,2 = window digits (right to left), 3 = sign
- num  out  4  digit code: 0–9 BCD, 14 = blank, 15 = minus

## Operation
- Reset (rst=0): bin_out=0, src_sel=0, offset=0, divider=0, tick=0, count=0, num=14.
- clr=1 (rst high): same values as reset at the next edge. clr overrides every other input that cycle.
- Arbitration:
  - req_b=1: bin_out←data_b, src_sel←1.
  - else req_a=1: bin_out←data_a, src_sel←0.
  - Both high: B wins and A's request is dropped, not queued.
  - Any load also forces offset←0. A load beats an l/r pulse in the same cycle.
- Offset (when no load/clr):
  - l alone: offset+1, saturating at MAX_OFF.
  - r alone: offset−1, saturating at 0.
  - l and r together: no change.
  - Pulses act in the clk domain immediately, so no pulse is lost between ticks.
- Divider: counts 0..CLK_DIV−1 and wraps. tick=1 for exactly the cycle in which the divider is at CLK_DIV−1. Not reset by clr, only by rst.
- Scan: on a tick cycle, count←count+1 (3 wraps to 0), and num is loaded with the code for the new count value, so count and num always match.
- Digit code for index k in {0,1,2}:
  - Position p = offset+k; digit d = bcd[4p+3:4p].
  - If p>0 and bcd digits p..4 are all zero, the code is 14 (blank). Otherwise it is d.
  - Position 0 is never blanked, so zero shows as "0".
- k = 3: code 15 if sign=1, else 14.
- The converter is combinational: bcd/sign reflect bin_out in the same cycle and are sampled at the tick.

## Timing
- Load latency: req at edge n appears on bin_out after edge n. It reaches num at the first tick after that, per digit.
- Offset latency: l/r at edge n updates offset after edge n, and num on the next tick.
- Tick period: exactly CLK_DIV cycles. First tick after reset release is at the CLK_DIV-th edge.
- Full frame (count 0→3→0): 4·CLK_DIV cycles.
- rst mid-frame: all outputs return to reset values immediately (asynchronous), without waiting for an edge.
- clr mid-frame: takes effect at the next edge. num shows 14 until the next tick re-evaluates.
- No handshake back to requesters: a load completes in one cycle and is always accepted unless it loses arbitration.

## Test plan
- Reset/release, CLK_DIV=4: rst=0 → bin_out=0, count=0, num=14. After release, tick on cycles 4, 8, 12…; count steps 1,2,3,0.
- Load and blanking: req_a with data_a=7, bcd=00007 → num sequence over one frame: count0=7, count1=14, count2=14, count3=14.
- Simultaneous request: req_a=1 (123) and req_b=1 (4567) same cycle → bin_out=4567, src_sel=1, offset=0.
- Scroll saturation: bcd=12345, apply l×3 → offset=2 and window digits 3,2,1. Then r×3 → offset=0 and digits 5,4,3.
- Sign digit: bcd=00042 with sign=1 → count3 code 15. With sign=0 → 14.
- Priority and clear: l pulse in the same cycle as req_b → offset=0. clr with req_b=1 → bin_out=0, src_sel=0, num=14.
